// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MULDIV_SIGNED_EN enables signed mult/div (Op[0]); otherwise all ops are unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MtHi,
    input  logic             MtLo,
    input  logic [WIDTH-1:0] HiLoIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [1:0]       dbg_state
);
    // Handshake: Start is taken on a rising edge only while Busy=0; Done pulses for one
    // cycle after HI/LO take the result, and a Start in that Done cycle is accepted.
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;

    assign a_neg = Op[0] & A[WIDTH-1];
    assign b_neg = Op[0] & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // Remainder follows the dividend sign, so a negative dividend over zero restores A.
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (state_q == ST_IDLE && Start) begin
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_op0;
    assign unused_op0 = Op[0];
    assign a_mag      = A;
    assign b_mag      = B;
    assign prod_fix   = acc_q;
    assign quo_fix    = acc_q[WIDTH-1:0];
    assign rem_fix    = acc_q[2*WIDTH-1:WIDTH];
`endif

    // Multiply: acc = {partial product, multiplier}; add on the multiplier LSB, shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, subtract if it fits.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_step;
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    assign div_step = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    is_div_d = Op[1];
                    div0_d   = (B == '0);
                    opnd_d   = Op[1] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
                    count_d  = '0;
                    state_d  = ST_RUN;
                end else begin
                    if (MtHi) hi_d = HiLoIn;
                    if (MtLo) lo_d = HiLoIn;
                end
            end
            ST_RUN: begin
                acc_d   = is_div_q ? div_step : mul_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign dbg_state = state_q;

endmodule
